// File: rtl/wb_pkg.sv
// Shared constants and state encoding for the writeback result stage.
package wb_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned REG_AW       = 4;
  localparam int unsigned LINK_REG     = 15;
  localparam int unsigned LOAD_TIMEOUT = 15;

  // LLW/LHW immediate lives in the low half of the ALU result.
  // LLW replaces the low half of the old value, LHW replaces the high half.
  localparam int unsigned HALF_W  = DATA_W / 2;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wbState_e;

endpackage

// File: rtl/wb_merge.sv
// Combinational writeback data/address select: CALL > LLW > LHW > ALU result.
// Feeds both the registered write port and the forwarding path.
module wb_merge #(
  parameter int unsigned DATA_W   = wb_pkg::DATA_W,
  parameter int unsigned REG_AW   = wb_pkg::REG_AW,
  parameter int unsigned LINK_REG = wb_pkg::LINK_REG
) (
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] oldReg,
  input  logic [DATA_W-1:0] pc,
  input  logic [REG_AW-1:0] destReg,
  input  logic              wbEn,
  input  logic              llwCmd,
  input  logic              lhwCmd,
  input  logic              callCmd,
  output logic [DATA_W-1:0] data,
  output logic [REG_AW-1:0] addr,
  output logic              we
);
  import wb_pkg::*;

  logic [HALF_W-1:0] imm;

  assign imm = aluResult[IMM_LSB +: HALF_W];

  always_comb begin
    data = aluResult;
    addr = destReg;
    // Register 0 is never written by ordinary ops.
    we   = wbEn && (destReg != '0);
    if (callCmd) begin
      data = pc + DATA_W'(1);
      addr = REG_AW'(LINK_REG);
      we   = 1'b1;
    end else if (llwCmd) begin
      data = {oldReg[DATA_W-1:HALF_W], imm};
    end else if (lhwCmd) begin
      data = {imm, oldReg[HALF_W-1:0]};
    end
  end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback result stage: one register-file write per accepted op, LOAD waits for memory.
// Optional zero-latency bypass outputs enabled by defining WB_FORWARD_EN.
module wb_result_stage #(
  parameter int unsigned DATA_W       = wb_pkg::DATA_W,
  parameter int unsigned REG_AW       = wb_pkg::REG_AW,
  parameter int unsigned LINK_REG     = wb_pkg::LINK_REG,
  parameter int unsigned LOAD_TIMEOUT = wb_pkg::LOAD_TIMEOUT
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iAluResult,
  input  logic [DATA_W-1:0] iOldReg,
  input  logic [REG_AW-1:0] iDestReg,
  input  logic              iWbEn,
  input  logic              iLoadCmd,
  input  logic              iLlwCmd,
  input  logic              iLhwCmd,
  input  logic              iCallCmd,
  input  logic [DATA_W-1:0] iPc,
  input  logic              iMemValid,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oRegWe,
  output logic [REG_AW-1:0] oRegAddr,
  output logic [DATA_W-1:0] oRegData,
  output logic              oLoadTimeout,
  output logic              oFwdValid,
  output logic [REG_AW-1:0] oFwdReg,
  output logic [DATA_W-1:0] oFwdData
);
  import wb_pkg::*;

  localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

  wbState_e          state;
  logic [CNT_W-1:0]  count;
  logic [REG_AW-1:0] loadReg;
  logic              loadWbEn;
  logic              loadWe;
  logic              accept;
  logic [DATA_W-1:0] mergeData;
  logic [REG_AW-1:0] mergeAddr;
  logic              mergeWe;

  assign oReady = (state == ST_IDLE);
  assign accept = iValid && oReady;
  assign loadWe = loadWbEn && (loadReg != '0);

  wb_merge #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .LINK_REG (LINK_REG)
  ) uMerge (
    .aluResult (iAluResult),
    .oldReg    (iOldReg),
    .pc        (iPc),
    .destReg   (iDestReg),
    .wbEn      (iWbEn),
    .llwCmd    (iLlwCmd),
    .lhwCmd    (iLhwCmd),
    .callCmd   (iCallCmd),
    .data      (mergeData),
    .addr      (mergeAddr),
    .we        (mergeWe)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state        <= ST_IDLE;
      count        <= '0;
      loadReg      <= '0;
      loadWbEn     <= 1'b0;
      oRegWe       <= 1'b0;
      oRegAddr     <= '0;
      oRegData     <= '0;
      oLoadTimeout <= 1'b0;
    end else begin
      oRegWe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (iLoadCmd) begin
              loadReg  <= iDestReg;
              loadWbEn <= iWbEn;
              count    <= '0;
              state    <= ST_WAIT_MEM;
            end else if (mergeWe) begin
              oRegWe   <= 1'b1;
              oRegAddr <= mergeAddr;
              oRegData <= mergeData;
            end
          end
        end
        ST_WAIT_MEM: begin
          // Data arriving on the timeout cycle still completes the load.
          if (iMemValid) begin
            state <= ST_IDLE;
            if (loadWe) begin
              oRegWe   <= 1'b1;
              oRegAddr <= loadReg;
              oRegData <= iMemData;
            end
          end else if (count == CNT_W'(LOAD_TIMEOUT)) begin
            oLoadTimeout <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  // Mirrors what the write port will present on the following cycle.
  always_comb begin
    oFwdValid = 1'b0;
    oFwdReg   = '0;
    oFwdData  = '0;
    if (state == ST_IDLE) begin
      if (accept && !iLoadCmd && mergeWe) begin
        oFwdValid = 1'b1;
        oFwdReg   = mergeAddr;
        oFwdData  = mergeData;
      end
    end else if (iMemValid && loadWe) begin
      oFwdValid = 1'b1;
      oFwdReg   = loadReg;
      oFwdData  = iMemData;
    end
  end
`else
  assign oFwdValid = 1'b0;
  assign oFwdReg   = '0;
  assign oFwdData  = '0;
`endif

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed self-checking bench for wb_result_stage; bypass checks follow WB_FORWARD_EN.
module tb_wb_result_stage;

  logic        iClk;
  logic        iReset;
  logic        iValid;
  logic        oReady;
  logic [31:0] iAluResult;
  logic [31:0] iOldReg;
  logic [3:0]  iDestReg;
  logic        iWbEn;
  logic        iLoadCmd;
  logic        iLlwCmd;
  logic        iLhwCmd;
  logic        iCallCmd;
  logic [31:0] iPc;
  logic        iMemValid;
  logic [31:0] iMemData;
  logic        oRegWe;
  logic [3:0]  oRegAddr;
  logic [31:0] oRegData;
  logic        oLoadTimeout;
  logic        oFwdValid;
  logic [3:0]  oFwdReg;
  logic [31:0] oFwdData;

  int errors = 0;
  int checks = 0;

  wb_result_stage dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iValid       (iValid),
    .oReady       (oReady),
    .iAluResult   (iAluResult),
    .iOldReg      (iOldReg),
    .iDestReg     (iDestReg),
    .iWbEn        (iWbEn),
    .iLoadCmd     (iLoadCmd),
    .iLlwCmd      (iLlwCmd),
    .iLhwCmd      (iLhwCmd),
    .iCallCmd     (iCallCmd),
    .iPc          (iPc),
    .iMemValid    (iMemValid),
    .iMemData     (iMemData),
    .oRegWe       (oRegWe),
    .oRegAddr     (oRegAddr),
    .oRegData     (oRegData),
    .oLoadTimeout (oLoadTimeout),
    .oFwdValid    (oFwdValid),
    .oFwdReg      (oFwdReg),
    .oFwdData     (oFwdData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bypass must show the next write only when the feature is built in.
  task automatic checkFwd(input string tag, input logic v, input logic [3:0] r,
                          input logic [31:0] d);
`ifdef WB_FORWARD_EN
    check({tag, "_fv"}, {31'b0, oFwdValid}, {31'b0, v});
    if (v) begin
      check({tag, "_fr"}, {28'b0, oFwdReg}, {28'b0, r});
      check({tag, "_fd"}, oFwdData, d);
    end
`else
    check({tag, "_fv"}, {31'b0, oFwdValid}, 32'h0);
    check({tag, "_fd"}, oFwdData, 32'h0);
`endif
  endtask

  task automatic checkWrite(input string tag, input logic we, input logic [3:0] a,
                            input logic [31:0] d);
    check({tag, "_we"}, {31'b0, oRegWe}, {31'b0, we});
    check({tag, "_addr"}, {28'b0, oRegAddr}, {28'b0, a});
    check({tag, "_data"}, oRegData, d);
  endtask

  task automatic clearIn();
    iValid = 0; iAluResult = 0; iOldReg = 0; iDestReg = 0; iWbEn = 0;
    iLoadCmd = 0; iLlwCmd = 0; iLhwCmd = 0; iCallCmd = 0; iPc = 0;
    iMemValid = 0; iMemData = 0;
  endtask

  task automatic op(input logic [31:0] alu, input logic [31:0] old, input logic [3:0] dest,
                    input logic wb, input logic ld, input logic llw, input logic lhw,
                    input logic call, input logic [31:0] pc);
    clearIn();
    iValid = 1; iAluResult = alu; iOldReg = old; iDestReg = dest; iWbEn = wb;
    iLoadCmd = ld; iLlwCmd = llw; iLhwCmd = lhw; iCallCmd = call; iPc = pc;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    clearIn();
    iReset = 1;
    tick(); tick();
    check("rst_ready", {31'b0, oReady}, 32'h1);
    checkWrite("rst", 1'b0, 4'd0, 32'h0);
    check("rst_timeout", {31'b0, oLoadTimeout}, 32'h0);
    iReset = 0;
    checkFwd("rst", 1'b0, 4'd0, 32'h0);

    // Back-to-back ALU / LLW / LHW
    op(32'h1234_5678, 32'h0, 4'd3, 1, 0, 0, 0, 0, 32'h0);
    #1 checkFwd("alu", 1'b1, 4'd3, 32'h1234_5678);
    tick();
    checkWrite("alu", 1'b1, 4'd3, 32'h1234_5678);
    op(32'h0000_BEEF, 32'hAAAA_5555, 4'd4, 1, 0, 1, 0, 0, 32'h0);
    #1 checkFwd("llw", 1'b1, 4'd4, 32'hAAAA_BEEF);
    tick();
    checkWrite("llw", 1'b1, 4'd4, 32'hAAAA_BEEF);
    op(32'h0000_BEEF, 32'hAAAA_5555, 4'd6, 1, 0, 0, 1, 0, 32'h0);
    tick();
    checkWrite("lhw", 1'b1, 4'd6, 32'hBEEF_5555);
    clearIn();
    tick();
    checkWrite("hold", 1'b0, 4'd6, 32'hBEEF_5555);
    op(32'h0000_BEEF, 32'hAAAA_5555, 4'd7, 1, 0, 1, 1, 0, 32'h0);
    tick();
    checkWrite("llw_lhw", 1'b1, 4'd7, 32'hAAAA_BEEF);

    // CALL overrides dest and iWbEn; PC wraps
    op(32'h0000_BEEF, 32'h0, 4'd2, 0, 0, 1, 0, 1, 32'hFFFF_FFFF);
    tick();
    checkWrite("call_wrap", 1'b1, 4'd15, 32'h0);
    op(32'h0, 32'h0, 4'd2, 1, 0, 0, 0, 1, 32'h100);
    tick();
    checkWrite("call", 1'b1, 4'd15, 32'h101);

    // Suppressed writes still consume the op
    op(32'h5, 32'h0, 4'd0, 1, 0, 0, 0, 0, 32'h0);
    #1 checkFwd("dest0", 1'b0, 4'd0, 32'h0);
    check("dest0_ready", {31'b0, oReady}, 32'h1);
    tick();
    checkWrite("dest0", 1'b0, 4'd15, 32'h101);
    op(32'h9, 32'h0, 4'd9, 0, 0, 0, 0, 0, 32'h0);
    tick();
    checkWrite("nowb", 1'b0, 4'd15, 32'h101);

    // LOAD with memory data three cycles later
    op(32'h0, 32'h0, 4'd5, 1, 1, 0, 0, 0, 32'h0);
    tick();
    clearIn();
    check("ld_rdy1", {31'b0, oReady}, 32'h0);
    check("ld_we1", {31'b0, oRegWe}, 32'h0);
    tick();
    check("ld_rdy2", {31'b0, oReady}, 32'h0);
    tick();
    check("ld_rdy3", {31'b0, oReady}, 32'h0);
    iMemValid = 1; iMemData = 32'hCAFE_F00D;
    #1 checkFwd("ld", 1'b1, 4'd5, 32'hCAFE_F00D);
    tick();
    clearIn();
    checkWrite("ld", 1'b1, 4'd5, 32'hCAFE_F00D);
    check("ld_rdy4", {31'b0, oReady}, 32'h1);

    // Memory data while idle is ignored
    iMemValid = 1; iMemData = 32'h1;
    tick();
    clearIn();
    checkWrite("idle_mem", 1'b0, 4'd5, 32'hCAFE_F00D);

    // Data on the final WAIT_MEM cycle wins over the timeout
    op(32'h0, 32'h0, 4'd10, 1, 1, 0, 0, 0, 32'h0);
    tick();
    clearIn();
    for (int i = 0; i < 15; i++) tick();
    check("race_rdy", {31'b0, oReady}, 32'h0);
    iMemValid = 1; iMemData = 32'h55;
    tick();
    clearIn();
    checkWrite("race", 1'b1, 4'd10, 32'h55);
    check("race_to", {31'b0, oLoadTimeout}, 32'h0);

    // Timeout: sixteen WAIT_MEM cycles (counter 0..15) then abort
    op(32'h0, 32'h0, 4'd8, 1, 1, 0, 0, 0, 32'h0);
    tick();
    clearIn();
    for (int i = 0; i < 15; i++) tick();
    check("to_pre", {31'b0, oLoadTimeout}, 32'h0);
    check("to_pre_rdy", {31'b0, oReady}, 32'h0);
    tick();
    check("to_set", {31'b0, oLoadTimeout}, 32'h1);
    check("to_rdy", {31'b0, oReady}, 32'h1);
    checkWrite("to", 1'b0, 4'd10, 32'h55);
    op(32'h77, 32'h0, 4'd1, 1, 0, 0, 0, 0, 32'h0);
    tick();
    clearIn();
    check("to_sticky", {31'b0, oLoadTimeout}, 32'h1);
    checkWrite("after_to", 1'b1, 4'd1, 32'h77);

    // Reset clears the sticky flag and drops an in-flight load
    iReset = 1;
    #1 check("to_clr", {31'b0, oLoadTimeout}, 32'h0);
    iReset = 0;
    tick();
    op(32'h0, 32'h0, 4'd11, 1, 1, 0, 0, 0, 32'h0);
    tick();
    clearIn();
    tick();
    iReset = 1;
    #1 iReset = 0;
    check("rst_wait_rdy", {31'b0, oReady}, 32'h1);
    iMemValid = 1; iMemData = 32'hDEAD_BEEF;
    tick();
    clearIn();
    checkWrite("rst_wait", 1'b0, 4'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
